des_round_ctrl: RTL and testbench
=================================

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n_i  in  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
REQ-003 in_valid_i  in  1  input block/key/mode valid.
REQ-004 in_ready_o  out  1  block can accept a job (high only in IDLE).
REQ-005 mode_i  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-006 data_i  in  64  post-IP block {L0[63:32], R0[31:0]}.
REQ-007 key_i  in  56  post-PC-1 key {C0[55:28], D0[27:0]}.
REQ-008 f_data_o  out  32  current R half, driven to the external F function.
REQ-009 f_key_o  out  48  current round subkey, driven to the external F function.
REQ-010 f_result_i  in  32  F function output, combinational from f_data_o/f_key_o.
REQ-011 out_valid_o  out  1  result valid.
REQ-012 out_ready_i  in  1  consumer accepts result.
REQ-013 data_o  out  64  pre-FP result {R16, L16} (final swap applied).
REQ-014 busy_o  out  1  high in RUN or DONE.
REQ-015 round_o  out  4  index of the round in progress (0..15); 0 outside RUN.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE, with reset state IDLE.
REQ-017 IDLE: in_ready_o=1; on in_valid_i=1, latch L=data_i[63:32], R=data_i[31:0], CD=key_i, mode=mode_i, round=0, go to RUN.
REQ-018 RUN: each cycle executes exactly one Feistel round: L<=R, R<=L^f_result_i, CD<=CD_next, round<=round+1.
REQ-019 f_data_o SHALL equal R; f_key_o SHALL equal PC-2(CD_next), using the FIPS 46-3 PC-2 table, with CD_next computed combinationally from registered CD.
REQ-020 Encrypt: CD_next is C and D each rotated left by S[round], with S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (index 0..15).
REQ-021 Decrypt: CD_next is C and D each rotated right by T[round], with T = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; round 0 uses CD unrotated.
REQ-022 Rotations SHALL be within each 28-bit half independently, with no carry between C and D.
REQ-023 After the round with round=15, go to DONE; round_o returns to 0.
REQ-024 DONE: out_valid_o=1 and data_o={R,L}; data_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-025 DONE with out_ready_i=1: go to IDLE on the next edge; the next accept is possible no earlier than the following cycle.
REQ-026 Latency: accept on edge N gives out_valid_o high after edge N+16 (16 RUN cycles); throughput is one block per 18 cycles minimum.
REQ-027 in_valid_i, mode_i, data_i and key_i SHALL be ignored outside IDLE; a mode change mid-job has no effect.
REQ-028 f_data_o and f_key_o are don't-care outside RUN but SHALL be driven from registers (no X).
REQ-029 data_o SHALL read 0 when out_valid_o=0.

Reset
REQ-030 rst_n_i=0 SHALL immediately force state=IDLE, L, R, CD, mode and round to 0, out_valid_o=0, busy_o=0 and in_ready_o=1, regardless of the current state.
REQ-031 Reset mid-RUN or mid-DONE SHALL discard the job silently, with no out_valid_o pulse after release.
REQ-032 The first accept SHALL be possible on the first rising edge with rst_n_i=1.

Verification
REQ-033 Encrypt: mode=0, key_i=F0CCAAF_556678F, data_i=CC00CCFF_F0AAF0AA -> f_key_o=1B02EFFC7072 in the first RUN cycle; data_o=0A4CD995_43423234 with out_valid_o on cycle +16.
REQ-034 Decrypt: mode=1, the same key_i, data_i=0A4CD995_43423234 -> first f_key_o=PC-2(key_i), i.e. K16; data_o=CC00CCFF_F0AAF0AA.
REQ-035 Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> data_o stable and in_ready_o=0 throughout; release -> IDLE the next cycle.
REQ-036 Ignored input: pulse in_valid_i with different data at round 7 -> result identical to REQ-033; no second job starts.
REQ-037 Reset abort: assert rst_n_i at round 9 -> all outputs at reset values asynchronously; a new REQ-033 job after release completes correctly.
REQ-038 Back-to-back: two encrypt jobs with out_ready_i tied high -> accepts 18 cycles apart; both results correct; round_o sequences 0..15 each job.

Source files
------------

// File: rtl/des_round_ctrl.sv
// DES round controller: runs 16 Feistel rounds around an external F function and
// derives each round subkey on the fly from the post-PC-1 key.
module des_round_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        mode_i,
  input  logic [63:0] data_i,
  input  logic [55:0] key_i,
  output logic [31:0] f_data_o,
  output logic [47:0] f_key_o,
  input  logic [31:0] f_result_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] data_o,
  output logic        busy_o,
  output logic [3:0]  round_o
);
  // state | meaning
  // IDLE  | waiting for a job, in_ready_o high
  // RUN   | one Feistel round per cycle, round_q = 0..15
  // DONE  | result held on data_o until out_ready_i
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [55:0] cd_q, cd_next;
  logic        mode_q;
  logic [3:0]  round_q;
  logic [1:0]  rot_amt;

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left,
                                        input logic [1:0] amt);
    logic [27:0] y;
    case ({left, amt})
      3'b101:  y = {x[26:0], x[27]};
      3'b110:  y = {x[25:0], x[27:26]};
      3'b001:  y = {x[0], x[27:1]};
      3'b010:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    logic [5:0]  idx;
    k = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2[i]);
      k   = {k[46:0], cd[idx]};
    end
    return k;
  endfunction

  // Decrypt walks the schedule backwards: right rotations, none in the first round.
  always_comb begin
    rot_amt = 2'd2;
    if (mode_q) begin
      if (round_q == 4'd0)
        rot_amt = 2'd0;
      else if (round_q == 4'd1 || round_q == 4'd8 || round_q == 4'd15)
        rot_amt = 2'd1;
    end else begin
      if (round_q == 4'd0 || round_q == 4'd1 || round_q == 4'd8 || round_q == 4'd15)
        rot_amt = 2'd1;
    end
    cd_next = {rot28(cd_q[55:28], !mode_q, rot_amt), rot28(cd_q[27:0], !mode_q, rot_amt)};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = RUN;
      RUN:     if (round_q == 4'd15) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q == RUN) || (state_q == DONE);
    round_o     = (state_q == RUN) ? round_q : 4'd0;
    data_o      = (state_q == DONE) ? {r_q, l_q} : 64'd0;
    f_data_o    = r_q;
    f_key_o     = pc2(cd_next);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      l_q     <= '0;
      r_q     <= '0;
      cd_q    <= '0;
      mode_q  <= 1'b0;
      round_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          l_q     <= data_i[63:32];
          r_q     <= data_i[31:0];
          cd_q    <= key_i;
          mode_q  <= mode_i;
          round_q <= 4'd0;
        end
        RUN: begin
          l_q     <= r_q;
          r_q     <= l_q ^ f_result_i;
          cd_q    <= cd_next;
          round_q <= (round_q == 4'd15) ? 4'd0 : round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: supplies the DES F function and checks against a
// whole-cipher reference built from the key schedule's cumulative shifts.
module tb_des_round_ctrl;
  localparam logic [55:0] KEY = 56'hF0CCAAF_556678F;
  localparam logic [63:0] PT  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] CT  = 64'h0A4CD995_43423234;

  localparam int E [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                            16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                            2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC2T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                               41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int CUM [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [63:0] data_in = '0;
  logic [55:0] key = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] f_data, f_result;
  logic [47:0] f_key;
  logic [63:0] data_out;
  logic [3:0]  round;
  int          total = 0, bad = 0;

  logic [47:0] m_fk [16];
  logic [31:0] m_fr [16];
  logic [63:0] m_out;

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e, x;
    logic [31:0] s, p;
    logic [5:0]  six;
    int          idx;
    e = '0;
    for (int i = 0; i < 48; i++) e = {e[46:0], r[5'(32 - E[i])]};
    x = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = 6'(x >> (42 - 6 * b));
      idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
      s   = {s[27:0], 4'(SBOX[b][idx])};
    end
    p = '0;
    for (int i = 0; i < 32; i++) p = {p[30:0], s[5'(32 - P[i])]};
    return p;
  endfunction

  function automatic logic [47:0] pc2_ref(input logic [55:0] cd);
    logic [47:0] k;
    k = '0;
    for (int i = 0; i < 48; i++) k = {k[46:0], cd[6'(56 - PC2T[i])]};
    return k;
  endfunction

  assign f_result = des_f(f_data, f_key);

  des_round_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .data_i(data_in), .key_i(key), .f_data_o(f_data), .f_key_o(f_key),
    .f_result_i(f_result), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(data_out), .busy_o(busy), .round_o(round));

  always #5 clk = ~clk;

  // Subkey i uses C0/D0 rotated left by the cumulative shift count; decrypt uses them reversed.
  task automatic model_job(input logic md, input logic [55:0] k, input logic [63:0] d);
    logic [47:0] ks [16];
    logic [27:0] c0, d0, ci, di;
    logic [31:0] l, r, t;
    c0 = k[55:28];
    d0 = k[27:0];
    for (int i = 0; i < 16; i++) begin
      ci    = (c0 << CUM[i]) | (c0 >> (28 - CUM[i]));
      di    = (d0 << CUM[i]) | (d0 >> (28 - CUM[i]));
      ks[i] = pc2_ref({ci, di});
    end
    l = d[63:32];
    r = d[31:0];
    for (int i = 0; i < 16; i++) begin
      m_fk[i] = md ? ks[15 - i] : ks[i];
      m_fr[i] = r;
      t = r;
      r = l ^ des_f(r, m_fk[i]);
      l = t;
    end
    m_out = {r, l};
  endtask

  task automatic do_job(input logic md, input logic [55:0] k, input logic [63:0] d,
                        input int hold, input int inj,
                        output logic [63:0] res, output logic [47:0] fk0);
    model_job(md, k, d);
    fk0 = '0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL job_ready: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1; mode = md; key = k; data_in = d; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({round, busy, in_ready, out_valid, f_data, f_key} !==
          {4'(i), 1'b1, 1'b0, 1'b0, m_fr[i], m_fk[i]}) begin
        bad++;
        $display("FAIL run_round%0d: round=%0d busy=%b rdy=%b ov=%b fd=%h fk=%h want fd=%h fk=%h",
                 i, round, busy, in_ready, out_valid, f_data, f_key, m_fr[i], m_fk[i]);
      end
      if (i == 0) fk0 = f_key;
      in_valid = (i == inj);
      mode     = 1'($urandom);
      data_in  = {$urandom, $urandom};
      key      = 56'({$urandom, $urandom});
      @(negedge clk);
    end
    in_valid = 1'b0;
    res = data_out;
    total++;
    if ({out_valid, busy, in_ready, round, data_out} !== {1'b1, 1'b1, 1'b0, 4'd0, m_out}) begin
      bad++;
      $display("FAIL done_state: ov=%b busy=%b rdy=%b round=%0d data=%h want data=%h",
               out_valid, busy, in_ready, round, data_out, m_out);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, data_out} !== {1'b1, 1'b0, m_out}) begin
        bad++;
        $display("FAIL done_hold%0d: ov=%b rdy=%b data=%h want %h", h, out_valid, in_ready,
                 data_out, m_out);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid, busy, data_out} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
      bad++;
      $display("FAIL release_idle: rdy=%b ov=%b busy=%b data=%h want 1 0 0 0",
               in_ready, out_valid, busy, data_out);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, busy, out_valid, round, data_out, f_data} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_state: rdy=%b busy=%b ov=%b round=%0d data=%h fd=%h",
               in_ready, busy, out_valid, round, data_out, f_data);
    end
  endtask

  task automatic test_encrypt();
    logic [63:0] res;
    logic [47:0] fk;
    do_job(1'b0, KEY, PT, 0, -1, res, fk);
    total++;
    if (fk !== 48'h1B02EFFC7072) begin
      bad++; $display("FAIL enc_first_key: got %h want 1b02effc7072", fk);
    end
    total++;
    if (res !== CT) begin
      bad++; $display("FAIL enc_result: got %h want %h", res, CT);
    end
  endtask

  task automatic test_decrypt();
    logic [63:0] res;
    logic [47:0] fk;
    do_job(1'b1, KEY, CT, 2, -1, res, fk);
    total++;
    if (fk !== pc2_ref(KEY)) begin
      bad++; $display("FAIL dec_first_key: got %h want %h", fk, pc2_ref(KEY));
    end
    total++;
    if (res !== PT) begin
      bad++; $display("FAIL dec_result: got %h want %h", res, PT);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res;
    logic [47:0] fk;
    do_job(1'b0, KEY, PT, 5, -1, res, fk);
    total++;
    if (res !== CT) begin
      bad++; $display("FAIL bp_result: got %h want %h", res, CT);
    end
  endtask

  task automatic test_ignored_input();
    logic [63:0] res;
    logic [47:0] fk;
    do_job(1'b0, KEY, PT, 1, 7, res, fk);
    total++;
    if (res !== CT) begin
      bad++; $display("FAIL ignored_result: got %h want %h", res, CT);
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] res;
    logic [47:0] fk;
    int seen, odd;
    in_valid = 1'b1; mode = 1'b0; key = KEY; data_in = PT;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (round === 4'd9 && busy === 1'b1) seen = 1;
      else @(negedge clk);
    end
    total++;
    if (seen == 0) begin
      bad++; $display("FAIL abort_reach_round9: round=%0d want 9", round);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, out_valid, round, data_out, f_data} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 32'd0}) begin
      bad++;
      $display("FAIL abort_async: rdy=%b busy=%b ov=%b round=%0d data=%h fd=%h",
               in_ready, busy, out_valid, round, data_out, f_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    odd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) odd++;
    end
    total++;
    if (odd != 0) begin
      bad++; $display("FAIL abort_silent: %0d cycles not idle, want 0", odd);
    end
    do_job(1'b0, KEY, PT, 0, -1, res, fk);
    total++;
    if (res !== CT) begin
      bad++; $display("FAIL abort_rerun: got %h want %h", res, CT);
    end
  endtask

  task automatic test_random();
    logic [63:0] res, d;
    logic [55:0] k;
    logic [47:0] fk;
    logic        md;
    for (int n = 0; n < 8; n++) begin
      md = 1'($urandom);
      k  = 56'({$urandom, $urandom});
      d  = {$urandom, $urandom};
      do_job(md, k, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 16)) - 1, res, fk);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] dat [2];
    logic [63:0] expv [2];
    int acc [2];
    int nacc, dd;
    for (int j = 0; j < 2; j++) begin
      dat[j] = {$urandom, $urandom};
      model_job(1'b0, KEY, dat[j]);
      expv[j] = m_out;
      acc[j] = -1;
    end
    nacc = 0;
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b0; key = KEY; data_in = dat[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int j = 0; j < 2; j++) begin
        if (acc[j] >= 0) begin
          dd = cyc - acc[j];
          if (dd >= 1 && dd <= 16) begin
            total++;
            if ({busy, round} !== {1'b1, 4'(dd - 1)}) begin
              bad++; $display("FAIL b2b_round j%0d: busy=%b round=%0d want %0d", j, busy, round, dd - 1);
            end
          end else if (dd == 17) begin
            total++;
            if ({out_valid, data_out} !== {1'b1, expv[j]}) begin
              bad++; $display("FAIL b2b_result j%0d: ov=%b data=%h want %h", j, out_valid, data_out, expv[j]);
            end
          end
        end
      end
      if (in_ready === 1'b1 && in_valid) begin
        if (nacc < 2) acc[nacc] = cyc;
        nacc++;
      end
      if (nacc == 1 && cyc > acc[0]) data_in = dat[1];
      if (nacc == 2 && cyc > acc[1]) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (nacc != 2 || acc[1] - acc[0] != 18) begin
      bad++; $display("FAIL b2b_spacing: accepts=%0d gap=%0d want 2 and 18", nacc, acc[1] - acc[0]);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_ignored_input();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
